// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, default target address
// and the bus ACK/NACK levels.
package i2c_pkg;

    localparam logic [6:0] I2C_DEFAULT_TGT_ADDR = 7'h5A;

    // Level seen on SDA during the ninth clock of a byte.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        TGT_IDLE    = 4'd0,
        TGT_DEV     = 4'd1,
        TGT_DEV_ACK = 4'd2,
        TGT_PTR     = 4'd3,
        TGT_PTR_ACK = 4'd4,
        TGT_WR      = 4'd5,
        TGT_WR_ACK  = 4'd6,
        TGT_RD      = 4'd7,
        TGT_RD_ACK  = 4'd8,
        TGT_IGNORE  = 4'd9
    } tgt_state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Oversampling front end for SCL/SDA: two-flop synchronizers, a delay stage,
// and SCL edge plus START/STOP detection. Shared by master and target.
module i2c_bus_monitor (
    input  logic clk,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;
    logic       scl_s;

    // Left unreset on purpose: after a reset the pipeline keeps tracking the
    // real pins, so a release of reset cannot fabricate a START or STOP.
    always_ff @(posedge clk) begin
        scl_sync <= {scl_sync[0], scl_i};
        sda_sync <= {sda_sync[0], sda_i};
        scl_d    <= scl_sync[1];
        sda_d    <= sda_sync[1];
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C register-file target: fixed 7-bit address, pointer-then-data protocol,
// auto-incrementing pointer retained across transactions.
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = I2C_DEFAULT_TGT_ADDR,
    parameter int         DEPTH    = 16,
    localparam int        PW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_pulse,
    output logic [PW-1:0] wr_ptr,
    output logic [7:0]    wr_data,
    output logic          done
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_bus_monitor u_mon (
        .clk       (clk),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    tgt_state_e    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [PW-1:0] ptr;
    logic [7:0]    mem [DEPTH];
    logic [1:0]    phase;
    logic          addressed;

    logic [7:0]    byte_in;
    logic          addr_match;

    // Byte as it stands once the bit currently on SDA is shifted in.
    assign byte_in    = {shreg[6:0], sda_s};
    assign addr_match = (byte_in[7:1] == DEV_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TGT_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            ptr       <= '0;
            phase     <= 2'd0;
            addressed <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_ptr    <= '0;
            wr_data   <= 8'h00;
            done      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            wr_pulse <= 1'b0;
            done     <= 1'b0;
            if (start_det) begin
                state   <= TGT_DEV;
                bit_cnt <= 3'd0;
                phase   <= 2'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state     <= TGT_IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                done      <= addressed;
                addressed <= 1'b0;
            end else begin
                case (state)
                    TGT_IDLE, TGT_IGNORE: begin
                    end

                    // Receive states: a byte only takes effect on its 8th rising edge,
                    // so anything cut short by START/STOP leaves no trace.
                    TGT_DEV, TGT_PTR, TGT_WR: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                phase <= 2'd0;
                                if (state == TGT_DEV) begin
                                    state <= addr_match ? TGT_DEV_ACK : TGT_IGNORE;
                                end else if (state == TGT_PTR) begin
                                    ptr   <= byte_in[PW-1:0];
                                    state <= TGT_PTR_ACK;
                                end else begin
                                    wr_pulse <= 1'b1;
                                    wr_ptr   <= ptr;
                                    wr_data  <= byte_in;
                                    mem[ptr] <= byte_in;
                                    ptr      <= ptr + PW'(1);
                                    state    <= TGT_WR_ACK;
                                end
                            end
                        end
                    end

                    // phase 0: waiting for the fall that ends bit 8 (start pulling low);
                    // phase 1: waiting for the fall that ends the ACK clock.
                    TGT_DEV_ACK, TGT_PTR_ACK, TGT_WR_ACK: begin
                        if (scl_fall) begin
                            if (phase == 2'd0) begin
                                sda_oe <= 1'b1;
                                phase  <= 2'd1;
                                if (state == TGT_DEV_ACK) begin
                                    addressed <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= 3'd0;
                                phase   <= 2'd0;
                                if (state == TGT_DEV_ACK && shreg[0]) begin
                                    state  <= TGT_RD;
                                    shreg  <= mem[ptr];
                                    sda_oe <= ~mem[ptr][7];
                                end else begin
                                    state  <= (state == TGT_DEV_ACK) ? TGT_PTR : TGT_WR;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                    end

                    TGT_RD: begin
                        if (scl_rise) begin
                            if (bit_cnt == 3'd7) begin
                                state   <= TGT_RD_ACK;
                                phase   <= 2'd0;
                                bit_cnt <= 3'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (scl_fall) begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sda_oe <= ~shreg[6];
                        end
                    end

                    // phase 0: release SDA for the master; phase 1: sample its ACK;
                    // phase 2: present the next byte after the ACK clock ends.
                    TGT_RD_ACK: begin
                        if (phase == 2'd0) begin
                            if (scl_fall) begin
                                sda_oe <= 1'b0;
                                phase  <= 2'd1;
                            end
                        end else if (phase == 2'd1) begin
                            if (scl_rise) begin
                                if (sda_s == I2C_ACK) begin
                                    ptr   <= ptr + PW'(1);
                                    phase <= 2'd2;
                                end else begin
                                    state <= TGT_IGNORE;
                                end
                            end
                        end else if (scl_fall) begin
                            shreg   <= mem[ptr];
                            sda_oe  <= ~mem[ptr][7];
                            bit_cnt <= 3'd0;
                            state   <= TGT_RD;
                        end
                    end

                    default: state <= TGT_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: a bit-banged I2C master drives the open-drain bus,
// a behavioural register-file model predicts writes and read data.
module tb_i2c_reg_target;

    localparam int         DEPTH = 16;
    localparam int         PW    = $clog2(DEPTH);
    localparam int         Q     = 6;
    localparam logic [6:0] ADDR  = 7'h5A;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          scl_m = 1'b1;
    logic          sda_m = 1'b1;
    logic          sda_oe;
    logic          busy;
    logic          wr_pulse;
    logic [PW-1:0] wr_ptr;
    logic [7:0]    wr_data;
    logic          done;
    logic          sda_line;

    assign sda_line = sda_m & ~sda_oe;

    i2c_reg_target #(.DEV_ADDR(ADDR), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .wr_ptr   (wr_ptr),
        .wr_data  (wr_data),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event recorder: only this block writes these.
    int            done_cnt = 0;
    int            oe_cnt   = 0;
    int            wr_cnt   = 0;
    logic [PW+7:0] wr_log [1024];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (sda_oe) oe_cnt++;
        if (wr_pulse) begin
            wr_log[wr_cnt] = {wr_ptr, wr_data};
            wr_cnt++;
        end
    end

    // Reference model and scoreboard state.
    logic [7:0]    model_mem [DEPTH];
    int            model_ptr;
    logic [PW+7:0] exp_q [$];
    logic [7:0]    exp_rd [$];
    logic [7:0]    wbuf [$];
    logic [7:0]    rbuf [$];
    logic [PW+7:0] exp_w;
    int            wr_seen = 0;
    logic          last_busy;

    // ---------------- master bus tasks ----------------
    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wait_q();
            scl_m = 1'b1; wait_q(); wait_q();
            scl_m = 1'b0; wait_q();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        write_bits(b, 8);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = (sda_line == 1'b0);
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_byte(output logic [7:0] b, input bit master_ack);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            scl_m = 1'b1; wait_q();
            b[i] = sda_line;
            wait_q();
            scl_m = 1'b0; wait_q();
        end
        sda_m = master_ack ? 1'b0 : 1'b1; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
        sda_m = 1'b1;
    endtask

    task automatic tx_write(input logic [6:0] a, input logic [7:0] pb, output int acks);
        bit ack;
        acks = 0;
        bus_start();
        last_busy = busy;
        write_byte({a, 1'b0}, ack);
        acks += int'(ack);
        if (ack) begin
            write_byte(pb, ack);
            acks += int'(ack);
            foreach (wbuf[i]) begin
                write_byte(wbuf[i], ack);
                acks += int'(ack);
            end
        end
        bus_stop();
    endtask

    task automatic tx_read(input bit set, input logic [7:0] pb, input int n, output int acks);
        bit ack;
        logic [7:0] b;
        acks = 0;
        rbuf.delete();
        bus_start();
        last_busy = busy;
        if (set) begin
            write_byte({ADDR, 1'b0}, ack); acks += int'(ack);
            write_byte(pb, ack);           acks += int'(ack);
            bus_start();
        end
        write_byte({ADDR, 1'b1}, ack);
        acks += int'(ack);
        for (int i = 0; i < n; i++) begin
            read_byte(b, i < n - 1);
            rbuf.push_back(b);
        end
        bus_stop();
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_ptr = 0;
    endtask

    task automatic model_write(input logic [6:0] a, input logic [7:0] pb);
        if (a != ADDR) return;
        model_ptr = int'(pb) % DEPTH;
        foreach (wbuf[i]) begin
            model_mem[model_ptr] = wbuf[i];
            exp_q.push_back({model_ptr[PW-1:0], wbuf[i]});
            model_ptr = (model_ptr + 1) % DEPTH;
        end
    endtask

    task automatic model_read(input bit set, input logic [7:0] pb, input int n);
        if (set) model_ptr = int'(pb) % DEPTH;
        exp_rd.delete();
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(model_mem[model_ptr]);
            if (i < n - 1) model_ptr = (model_ptr + 1) % DEPTH;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        total++; if (sda_oe !== 1'b0)   begin bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
        total++; if (wr_ptr !== '0)     begin bad++; $display("FAIL reset_wr_ptr: got %h want 0", wr_ptr); end
        total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_basic_write();
        int acks;
        int d0;
        d0 = done_cnt;
        wbuf = '{8'h3C};
        model_write(ADDR, 8'h05);
        tx_write(ADDR, 8'h05, acks);
        total++; if (acks !== 3) begin bad++; $display("FAIL basic_acks: got %0d want 3", acks); end
        total++; if (last_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_mid: got %b want 1", last_busy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done: got %0d want 1", done_cnt - d0); end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            total++;
            if (wr_seen >= wr_cnt) begin bad++; $display("FAIL basic_wr: got none want %h", exp_w); end
            else begin
                if (wr_log[wr_seen] !== exp_w) begin bad++; $display("FAIL basic_wr: got %h want %h", wr_log[wr_seen], exp_w); end
                wr_seen++;
            end
        end
        total++; if (wr_cnt !== wr_seen) begin bad++; $display("FAIL basic_extra_wr: got %0d want %0d", wr_cnt, wr_seen); wr_seen = wr_cnt; end
    endtask

    task automatic test_set_read();
        int acks;
        int d0;
        d0 = done_cnt;
        model_read(1'b1, 8'h05, 1);
        tx_read(1'b1, 8'h05, 1, acks);
        total++; if (acks !== 3) begin bad++; $display("FAIL setrd_acks: got %0d want 3", acks); end
        total++; if (rbuf[0] !== exp_rd[0]) begin bad++; $display("FAIL setrd_data: got %h want %h", rbuf[0], exp_rd[0]); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL setrd_done: got %0d want 1", done_cnt - d0); end
        total++; if (wr_cnt !== wr_seen) begin bad++; $display("FAIL setrd_extra_wr: got %0d want %0d", wr_cnt, wr_seen); wr_seen = wr_cnt; end
    endtask

    task automatic test_mismatch();
        int acks;
        int d0;
        int o0;
        d0 = done_cnt;
        o0 = oe_cnt;
        wbuf = '{8'h77};
        model_write(7'h10, 8'h02);
        tx_write(7'h10, 8'h02, acks);
        total++; if (acks !== 0) begin bad++; $display("FAIL mismatch_ack: got %0d want 0", acks); end
        total++; if (oe_cnt - o0 !== 0) begin bad++; $display("FAIL mismatch_oe: got %0d cycles want 0", oe_cnt - o0); end
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL mismatch_done: got %0d want 0", done_cnt - d0); end
        total++; if (wr_cnt !== wr_seen) begin bad++; $display("FAIL mismatch_wr: got %0d want %0d", wr_cnt, wr_seen); wr_seen = wr_cnt; end
    endtask

    task automatic test_burst_wrap();
        int acks;
        wbuf = '{8'h5D};
        model_write(ADDR, 8'h01);
        tx_write(ADDR, 8'h01, acks);
        wbuf = '{8'hA1, 8'hB2, 8'hC3};
        model_write(ADDR, 8'h0E);
        tx_write(ADDR, 8'h0E, acks);
        total++; if (acks !== 5) begin bad++; $display("FAIL wrap_acks: got %0d want 5", acks); end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            total++;
            if (wr_seen >= wr_cnt) begin bad++; $display("FAIL wrap_wr: got none want %h", exp_w); end
            else begin
                if (wr_log[wr_seen] !== exp_w) begin bad++; $display("FAIL wrap_wr: got %h want %h", wr_log[wr_seen], exp_w); end
                wr_seen++;
            end
        end
        total++; if (wr_cnt !== wr_seen) begin bad++; $display("FAIL wrap_extra_wr: got %0d want %0d", wr_cnt, wr_seen); wr_seen = wr_cnt; end
        model_read(1'b0, 8'h00, 1);
        tx_read(1'b0, 8'h00, 1, acks);
        total++; if (rbuf[0] !== exp_rd[0]) begin bad++; $display("FAIL wrap_cur_read: got %h want %h", rbuf[0], exp_rd[0]); end
        model_read(1'b1, 8'h0E, 3);
        tx_read(1'b1, 8'h0E, 3, acks);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rbuf[i] !== exp_rd[i]) begin bad++; $display("FAIL wrap_read[%0d]: got %h want %h", i, rbuf[i], exp_rd[i]); end
        end
    endtask

    task automatic test_random();
        int acks;
        int kind;
        int n;
        int want;
        logic [7:0] pb;
        logic [6:0] a;
        for (int it = 0; it < 20; it++) begin
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 4);
            pb   = 8'($urandom_range(0, 255));
            if (kind == 0 || kind == 3) begin
                a = (kind == 0) ? ADDR : (ADDR ^ 7'($urandom_range(1, 127)));
                wbuf.delete();
                for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom_range(0, 255)));
                model_write(a, pb);
                tx_write(a, pb, acks);
                want = (kind == 0) ? n + 2 : 0;
                total++; if (acks !== want) begin bad++; $display("FAIL rand_wr_acks[%0d]: got %0d want %0d", it, acks, want); end
                while (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    total++;
                    if (wr_seen >= wr_cnt) begin bad++; $display("FAIL rand_wr[%0d]: got none want %h", it, exp_w); end
                    else begin
                        if (wr_log[wr_seen] !== exp_w) begin bad++; $display("FAIL rand_wr[%0d]: got %h want %h", it, wr_log[wr_seen], exp_w); end
                        wr_seen++;
                    end
                end
                total++; if (wr_cnt !== wr_seen) begin bad++; $display("FAIL rand_extra_wr[%0d]: got %0d want %0d", it, wr_cnt, wr_seen); wr_seen = wr_cnt; end
            end else begin
                model_read(kind == 1, pb, n);
                tx_read(kind == 1, pb, n, acks);
                want = (kind == 1) ? 3 : 1;
                total++; if (acks !== want) begin bad++; $display("FAIL rand_rd_acks[%0d]: got %0d want %0d", it, acks, want); end
                for (int i = 0; i < n; i++) begin
                    total++;
                    if (rbuf[i] !== exp_rd[i]) begin bad++; $display("FAIL rand_rd[%0d.%0d]: got %h want %h", it, i, rbuf[i], exp_rd[i]); end
                end
            end
        end
    endtask

    task automatic test_abort();
        int acks;
        int d0;
        bit ack;
        logic [7:0] pb;
        pb = 8'($urandom_range(0, 255));
        wbuf = '{8'hE7, 8'h18};
        model_write(ADDR, pb);
        tx_write(ADDR, pb, acks);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            total++;
            if (wr_seen >= wr_cnt) begin bad++; $display("FAIL abort_pre_wr: got none want %h", exp_w); end
            else begin
                if (wr_log[wr_seen] !== exp_w) begin bad++; $display("FAIL abort_pre_wr: got %h want %h", wr_log[wr_seen], exp_w); end
                wr_seen++;
            end
        end
        // Pointer byte completes, then STOP lands after half a data byte.
        d0 = done_cnt;
        bus_start();
        write_byte({ADDR, 1'b0}, ack);
        write_byte(pb, ack);
        write_bits(8'($urandom_range(0, 255)), 4);
        bus_stop();
        model_ptr = int'(pb) % DEPTH;
        total++; if (wr_cnt !== wr_seen) begin bad++; $display("FAIL abort_no_wr: got %0d want %0d", wr_cnt, wr_seen); wr_seen = wr_cnt; end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL abort_done: got %0d want 1", done_cnt - d0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        model_read(1'b0, 8'h00, 1);
        tx_read(1'b0, 8'h00, 1, acks);
        total++; if (rbuf[0] !== exp_rd[0]) begin bad++; $display("FAIL abort_ptr_kept: got %h want %h", rbuf[0], exp_rd[0]); end
        // Reset halfway through the address byte of the next frame.
        d0 = done_cnt;
        bus_start();
        write_bits({ADDR, 1'b0}, 4);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rstmid_sda_oe: got %b want 0", sda_oe); end
        bus_stop();
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL rstmid_done: got %0d want 0", done_cnt - d0); end
        total++; if (wr_cnt !== wr_seen) begin bad++; $display("FAIL rstmid_wr: got %0d want %0d", wr_cnt, wr_seen); wr_seen = wr_cnt; end
        pb = 8'($urandom_range(0, 255));
        wbuf = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        model_write(ADDR, pb);
        tx_write(ADDR, pb, acks);
        total++; if (acks !== 4) begin bad++; $display("FAIL post_rst_acks: got %0d want 4", acks); end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            total++;
            if (wr_seen >= wr_cnt) begin bad++; $display("FAIL post_rst_wr: got none want %h", exp_w); end
            else begin
                if (wr_log[wr_seen] !== exp_w) begin bad++; $display("FAIL post_rst_wr: got %h want %h", wr_log[wr_seen], exp_w); end
                wr_seen++;
            end
        end
        model_read(1'b1, pb, 3);
        tx_read(1'b1, pb, 3, acks);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rbuf[i] !== exp_rd[i]) begin bad++; $display("FAIL post_rst_read[%0d]: got %h want %h", i, rbuf[i], exp_rd[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_set_read();
        test_mismatch();
        test_burst_wrap();
        test_random();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_reg_target.md
# i2c_reg_target

I2C responder (target) that answers transactions from the team's `i2c_top` master on the shared SCL/SDA bus. It matches a fixed 7-bit device address and exposes an internal byte-wide register file through a standard pointer-then-data protocol, with pointer auto-increment on bursts. It oversamples the bus with the system clock, so no SCL-domain logic exists.

## Interface
- `DEV_ADDR`, default 7'h5A: 7-bit address this target responds to.
- `DEPTH`, default 16: register-file depth in bytes, power of 2, 2..256.
- `clk`  in  1: system clock; must be ≥ 8× SCL frequency.
- `rst`  in  1: synchronous, active-high reset.
- `scl_i`  in  1: raw SCL pin level.
- `sda_i`  in  1: raw SDA pin level.
- `sda_oe`  out  1: 1 = pull SDA low (open-drain); 0 = release.
- `busy`  out  1: high from detected START until detected STOP.
- `wr_pulse`  out  1: one-cycle strobe when a data byte is committed to the register file.
- `wr_ptr`  out  $clog2(DEPTH): register index written; valid with `wr_pulse`.
- `wr_data`  out  8: byte written; valid with `wr_pulse`.
- `done`  out  1: one-cycle pulse on STOP that ends an addressed transaction.

## Operation
- Bus front end:
  - Each of SCL and SDA passes through a 2-flop synchronizer followed by a delay flop.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Data is sampled on the SCL rising edge. `sda_oe` changes only on the cycle after a detected SCL falling edge.
- Frame formats:
  - Write: S, DEV_ADDR+W, pointer byte, data bytes…, P.
  - Set-and-read: S, DEV_ADDR+W, pointer, Sr, DEV_ADDR+R, data…, P.
  - Current read: S, DEV_ADDR+R, data…, P. Reads from the retained pointer.
- Pointer:
  - Only the low $clog2(DEPTH) bits of the pointer byte are used.
  - Post-increments after each written byte and after each read byte that the master ACKs.
  - Wraps DEPTH-1 → 0.
  - Retained across transactions; reset value 0.
- Register file: DEPTH×8, reset value 0.
- FSM states and transitions:
  - IDLE: waits for START.
  - DEV: shifts in 8 bits.
    - Address match → DEV_ACK.
    - Mismatch → IGNORE; `sda_oe` is never asserted.
  - DEV_ACK: drives ACK.
    - R/W=0 → PTR.
    - R/W=1 → RD: loads the shift register from mem[ptr] and drives the MSB.
  - PTR → PTR_ACK: latch pointer, then → WR.
  - WR: shifts in 8 bits.
    - On the 8th rising edge, commits the byte: `wr_pulse`, mem write, pointer+1.
    - → WR_ACK, which ACKs every byte, then back to WR.
  - RD: shifts out 8 bits MSB first, then samples the master ACK in RD_ACK.
    - ACK (SDA=0) → reload from the new pointer, back to RD.
    - NACK → IGNORE.
  - IGNORE: waits for START or STOP.
- Global overrides, valid from any state:
  - START → DEV, including repeated START.
  - STOP → IDLE.
  - A byte interrupted by either is discarded: no `wr_pulse`, pointer unchanged.
- A START and a STOP are never detected in the same cycle. If SDA changes while SCL is high mid-byte, the START/STOP rule applies.
- `done` fires only if the transaction passed DEV_ACK.

## Timing
- Detection latency: 3 clk from pin change to internal START/STOP/edge event.
- ACK drive:
  - `sda_oe` rises 1 clk after the detected falling edge of SCL pulse 8.
  - It releases 1 clk after the detected falling edge of SCL pulse 9.
- Read data: each bit is driven 1 clk after the detected SCL falling edge that precedes it, and held until the next detected falling edge.
- After the master's ACK slot, `sda_oe` is released before the next bit unless that bit is 0.
- `wr_pulse` asserts 1 clk after the detected 8th rising edge of a WR byte. The mem write lands on the same clock edge, so it is readable on the following cycle.
- Reset values of outputs: `sda_oe`=0, `busy`=0, `wr_pulse`=0, `wr_ptr`=0, `wr_data`=0, `done`=0.
- Reset mid-transfer: next cycle is IDLE, SDA is released, and no partial byte is written.

## Structure
- Add to `i2c_pkg`:
  - a `typedef enum logic [3:0]` for the target FSM states (IDLE, DEV, DEV_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE);
  - the constant `I2C_DEFAULT_TGT_ADDR` = 7'h5A;
  - the ACK/NACK level constants.
- Sub-module `i2c_bus_monitor`: synchronizers plus edge/START/STOP detection. It outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det` and `sda_s`. This is reusable by the master.
- Top module `i2c_reg_target` contains the FSM, the 3-bit bit counter, the shift register, the pointer and the memory.

## Test plan
- Basic write: `i2c_top` writes pointer 0x05, data 0x3C to 0x5A → three ACKs; `wr_pulse` with `wr_ptr`=5, `wr_data`=0x3C; `done` pulses once.
- Set-and-read: pointer 0x05, then Sr + read → master receives 0x3C, master NACK, P; `ack_err`=0.
- Address mismatch: transaction to 0x10 → `sda_oe` stays 0 for the whole frame; `ack_err`=1 at the master; no `wr_pulse`; no `done`.
- Burst wrap: pointer 0x0E, data 0xA1 0xB2 0xC3 → mem[14]=A1, mem[15]=B2, mem[0]=C3; pointer ends at 1; a current read returns the byte at index 1.
- Abort: STOP after 4 data bits, then reset asserted mid-DEV on the next frame → no write, `busy`=0, `sda_oe`=0; the next full write succeeds.
